// File: rtl/serial_load_ctrl.sv
// Framed serial-to-parallel loader with optional even parity.
// Emits a one-cycle load strobe that feeds the S pins of a hold-register bank.
module serial_load_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_LOAD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic             w_last;
    logic             w_par_ok;
    logic [WIDTH-1:0] w_sr_nx;

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_par_ok = (sin_data == ^r_sr);
    assign w_sr_nx  = {r_sr[WIDTH-2:0], sin_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sin_valid && w_last) begin
                    w_next = PARITY_EN ? S_PARITY : S_LOAD;
                end
            end
            S_PARITY: begin
                if (sin_valid) begin
                    w_next = w_par_ok ? S_LOAD : S_IDLE;
                end
            end
            S_LOAD: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The word is published on the edge that enters LOAD, so it is
    // already valid while the strobe is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr  <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (sin_valid) begin
                        r_sr  <= w_sr_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last && !PARITY_EN) begin
                            r_data <= w_sr_nx;
                        end
                    end
                end
                S_PARITY: begin
                    if (sin_valid) begin
                        if (w_par_ok) begin
                            r_data <= r_sr;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                end
            endcase
        end
    end

    always_comb begin
        load     = (r_state == S_LOAD);
        busy     = (r_state != S_IDLE);
        err      = r_err;
        data_out = r_data;
    end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: directed frames plus randomized frames
// checked against a frame-level model of word, parity and timing.
module tb_serial_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sin_valid;
    logic       sin_data;
    logic [7:0] data_out;
    logic       load;
    logic       busy;
    logic       err;

    logic       start0;
    logic       v0;
    logic       d0;
    logic [7:0] data0;
    logic       load0;
    logic       busy0;
    logic       err0;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_data;
    int         cyc = 0;
    int         loads[$];

    typedef int stall_t[9];

    always #5 clk = ~clk;

    serial_load_ctrl #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sin_valid(sin_valid), .sin_data(sin_data),
        .data_out(data_out), .load(load), .busy(busy), .err(err)
    );

    serial_load_ctrl #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .sin_valid(v0), .sin_data(d0),
        .data_out(data0), .load(load0), .busy(busy0), .err(err0)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) loads.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            sin_valid = 1'b0;
            tick();
            n_tests++;
            if ({load, err, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL stall: got leb=%b want 001", {load, err, busy});
            end
        end
        sin_valid = 1'b1;
        sin_data  = b;
        tick();
        sin_valid = 1'b0;
    endtask

    // Model: good frame publishes w one cycle after the parity bit;
    // bad parity pulses err and leaves the last good word in place.
    task automatic send_frame(input logic [7:0] w, input bit bad,
                              input stall_t st, input bit hold);
        logic p;
        p = (^w) ^ bad;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        n_tests++;
        if ({load, err, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL start: got leb=%b want 001", {load, err, busy});
        end
        for (int i = 7; i >= 0; i--) begin
            drive_bit(w[i], st[7-i]);
            n_tests++;
            if ({load, err, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL bit%0d: got leb=%b want 001", i, {load, err, busy});
            end
        end
        drive_bit(p, st[8]);
        n_tests++;
        if (!bad) begin
            exp_data = w;
            if ({load, err, busy, data_out} !== {3'b101, w}) begin
                n_fail++;
                $display("FAIL load %h: got lebd=%b/%h want 101/%h",
                         w, {load, err, busy}, data_out, w);
            end
        end else begin
            if ({load, err, busy, data_out} !== {3'b010, exp_data}) begin
                n_fail++;
                $display("FAIL perr %h: got lebd=%b/%h want 010/%h",
                         w, {load, err, busy}, data_out, exp_data);
            end
        end
        tick();
        n_tests++;
        if ({load, err, busy, data_out} !== {3'b000, exp_data}) begin
            n_fail++;
            $display("FAIL after %h: got lebd=%b/%h want 000/%h",
                     w, {load, err, busy}, data_out, exp_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_data = 8'h00;
        n_tests++;
        if ({load, err, busy, data_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset: got lebd=%b/%h want 000/00",
                     {load, err, busy}, data_out);
        end
        n_tests++;
        if ({load0, err0, busy0, data0} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset0: got lebd=%b/%h want 000/00",
                     {load0, err0, busy0}, data0);
        end
    endtask

    task automatic test_basic();
        stall_t st = '{default: 0};
        send_frame(8'hA5, 1'b0, st, 1'b0);
    endtask

    task automatic test_bad_parity();
        stall_t st = '{default: 0};
        send_frame(8'hA5, 1'b1, st, 1'b0);
        send_frame(8'h5B, 1'b1, st, 1'b0);
    endtask

    task automatic test_stalls();
        stall_t st = '{default: 0};
        st[3] = 3;
        st[8] = 1;
        send_frame(8'h3C, 1'b0, st, 1'b0);
    endtask

    task automatic test_reset_mid();
        stall_t st = '{default: 0};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_data = 8'h00;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({load, err, busy, data_out} !== 11'd0) begin
                n_fail++;
                $display("FAIL midreset%0d: got lebd=%b/%h want 000/00",
                         k, {load, err, busy}, data_out);
            end
            tick();
        end
        send_frame(8'h81, 1'b0, st, 1'b0);
    endtask

    task automatic test_back_to_back();
        stall_t st = '{default: 0};
        loads.delete();
        send_frame(8'h12, 1'b0, st, 1'b1);
        send_frame(8'h34, 1'b0, st, 1'b1);
        start = 1'b0;
        tick();
        n_tests++;
        if (loads.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", loads.size());
        end else begin
            n_tests++;
            if (loads[1] - loads[0] != 11) begin
                n_fail++;
                $display("FAIL b2b_gap: got %0d want 11", loads[1] - loads[0]);
            end
        end
    endtask

    task automatic test_random();
        stall_t st;
        logic [7:0] w;
        bit bad;
        for (int f = 0; f < 10; f++) begin
            w   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            foreach (st[k]) st[k] = $urandom_range(0, 2);
            send_frame(w, bad, st, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_no_parity();
        logic [7:0] w;
        w = 8'hC3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            v0 = 1'b1;
            d0 = w[i];
            tick();
            v0 = 1'b0;
            if (i > 0) begin
                n_tests++;
                if ({load0, err0, busy0} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL np_bit%0d: got leb=%b want 001",
                             i, {load0, err0, busy0});
                end
            end
        end
        n_tests++;
        if ({load0, err0, busy0, data0} !== {3'b101, w}) begin
            n_fail++;
            $display("FAIL np_load: got lebd=%b/%h want 101/%h",
                     {load0, err0, busy0}, data0, w);
        end
        v0 = 1'b1;
        d0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({load0, err0, busy0, data0} !== {3'b000, w}) begin
                n_fail++;
                $display("FAIL np_idle%0d: got lebd=%b/%h want 000/%h",
                         k, {load0, err0, busy0}, data0, w);
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        sin_valid = 1'b0;
        sin_data  = 1'b0;
        start0    = 1'b0;
        v0        = 1'b0;
        d0        = 1'b0;
        test_reset();
        test_basic();
        test_bad_parity();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_no_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_load_ctrl.md
Name: serial_load_ctrl

Overview:
- Upstream feeder for the single-bit hold-register stage (mux-select flop: Q follows I1 when S=1, else holds).
- Deserialises a framed serial bit stream into a WIDTH-bit word, checks optional even parity, and emits a one-cycle load strobe.
- Downstream, data_out drives the per-bit I1 inputs of WIDTH hold stages and load drives their shared S, so a word is captured only on a good frame.

Parameters:
- WIDTH, 8, data word width in bits; legal range >= 2.
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  frame start request; sampled only in IDLE.
- sin_valid  in  1  qualifies sin_data this cycle.
- sin_data  in  1  serial data bit, MSB first.
- data_out  out  WIDTH  last good word; drives hold-stage I1 inputs.
- load  out  1  one-cycle strobe; drives hold-stage S.
- busy  out  1  high while a frame is in progress.
- err  out  1  one-cycle parity-error pulse.

Behaviour:
- Reset: rst_n=0 at a rising clk edge forces state=IDLE, shift reg=0, bit counter=0, data_out=0, load=0, busy=0, err=0.
- Reset applies mid-frame too; any partial frame is discarded with no load and no err.
- FSM states: IDLE, SHIFT, PARITY, LOAD.
- IDLE:
  - start=1 -> SHIFT, counter=0, shift reg cleared.
  - sin_valid is ignored in IDLE.
- SHIFT:
  - Each cycle with sin_valid=1: sr <= {sr[WIDTH-2:0], sin_data}, counter++.
  - sin_valid=0 stalls with no state change; there is no timeout.
  - When the bit accepted is number WIDTH-1 (counter==WIDTH-1 with sin_valid=1): go to PARITY if PARITY_EN=1, else LOAD.
- PARITY:
  - Waits for sin_valid=1, then compares sin_data with XOR of sr (even parity).
  - Match -> LOAD.
  - Mismatch -> err=1 for exactly one cycle (the cycle after the bad bit), then IDLE; data_out unchanged, load stays 0.
- LOAD:
  - Lasts exactly one cycle with load=1, and data_out already equals the new word in that same cycle (data_out <= sr on the edge that enters LOAD).
  - Next state is always IDLE.
- Latency: load is asserted the cycle immediately after the final accepted bit (the parity bit, or data bit WIDTH-1 when PARITY_EN=0).
- Hold-stage capture: downstream flops capture data_out on the edge at the end of the LOAD cycle.
- busy = 1 in SHIFT, PARITY and LOAD; 0 in IDLE.
- start is ignored in SHIFT, PARITY and LOAD. A start held high through LOAD is honoured in the following IDLE cycle, so the minimum frame spacing is one IDLE cycle.
- data_out changes only on entry to LOAD or on reset; it holds its value across failed frames.
- load and err are never high in the same cycle.
- Counter width is clog2(WIDTH)+1 bits and never wraps, since it is cleared on every start.

Test Plan:
- Reset, WIDTH=8, PARITY_EN=1: start, bits of 0xA5 MSB-first, parity 0 -> load=1 for one cycle exactly one cycle after the parity bit; data_out=0xA5; err=0; busy drops after LOAD.
- Bad parity: frame 0xA5 with parity 1 -> err pulse of one cycle, load never asserted, data_out keeps previous value (0x00 after reset, or 0xA5 after the prior test).
- Stalls: frame 0x3C with sin_valid deasserted for 3 cycles after bit 2 and 1 cycle before parity -> data_out=0x3C, load one cycle; no bits double-shifted or dropped.
- Reset mid-frame: rst_n=0 for one cycle after 4 bits of 0xFF -> state IDLE, busy=0, data_out=0, no load/err; a following full frame 0x81 loads 0x81.
- Back-to-back with start held high: frames 0x12 then 0x34 -> exactly two load pulses separated by one IDLE cycle plus 9 bit cycles; data_out 0x12 then 0x34.
- PARITY_EN=0 build: frame 0xC3 -> load one cycle after bit 7, data_out=0xC3; a 9th valid bit in IDLE is ignored.
